// File: rtl/pwm_mon_pkg.sv
// Shared definitions for the pwm pulse monitor: register offsets, bit indices, FSM states.
package pwm_mon_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_HIGH   = 2'd1;
  localparam logic [1:0] REG_PERIOD = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_IRQ_EN = 1;
  localparam int unsigned CTRL_CLR    = 2;

  localparam int unsigned ST_VALID   = 0;
  localparam int unsigned ST_TIMEOUT = 1;
  localparam int unsigned ST_OVF     = 2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RISE,
    HIGH,
    LOW
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/pwm_mon_edge.sv
// Synchroniser, optional majority glitch filter (PWM_MON_FILTER_EN) and registered rise/fall pulses.
module pwm_mon_edge
  import pwm_mon_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pwm,
  output logic o_rise,
  output logic o_fall
);

  logic [1:0] r_sync;
  logic       r_lvl_d;
  logic       r_rise;
  logic       r_fall;
  logic       w_lvl;

`ifdef PWM_MON_FILTER_EN
  logic [1:0] r_hist;
  logic       r_filt;

  // Two-of-three vote over consecutive samples; adds two cycles to both edges alike.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hist <= '0;
      r_filt <= 1'b0;
    end else begin
      r_hist <= {r_hist[0], r_sync[1]};
      r_filt <= maj3(r_sync[1], r_hist[0], r_hist[1]);
    end
  end

  assign w_lvl = r_filt;
`else
  assign w_lvl = r_sync[1];
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync  <= '0;
      r_lvl_d <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_pwm};
      r_lvl_d <= w_lvl;
      r_rise  <= w_lvl & ~r_lvl_d;
      r_fall  <= ~w_lvl & r_lvl_d;
    end
  end

  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/pwm_pulse_monitor.sv
// APB3 pulse monitor: measures high time and period of pwm_in, flags timeout/overflow.
// Build option PWM_MON_FILTER_EN enables the glitch filter inside pwm_mon_edge.
module pwm_pulse_monitor
  import pwm_mon_pkg::*;
#(
  parameter int unsigned CNT_W   = 24,
  parameter int unsigned TIMEOUT = 2_000_000
) (
  input  logic        PCLK,
  input  logic        PRESERN,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic [31:0] PRDATA,
  input  logic        pwm_in,
  output logic        irq
);

  localparam int unsigned       IDLE_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  state_t             r_state;
  logic               r_en;
  logic               r_irq_en;
  logic               r_valid;
  logic               r_timeout;
  logic               r_ovf;
  logic [CNT_W-1:0]   r_high;
  logic [CNT_W-1:0]   r_period;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_hcnt;
  logic [IDLE_W-1:0]  r_idle;

  logic w_rise, w_fall, w_any_edge;
  logic w_wr, w_wr_ctrl, w_wr_stat, w_clr, w_en_nxt;
  logic w_cnt_sat, w_hcnt_sat;
  logic w_unused;

  pwm_mon_edge u_edge (
    .i_clk  (PCLK),
    .i_rst  (PRESERN),
    .i_pwm  (pwm_in),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  assign w_any_edge = w_rise | w_fall;
  assign w_wr       = PSEL & PENABLE & PWRITE;
  assign w_wr_ctrl  = w_wr && (PADDR[3:2] == REG_CTRL);
  assign w_wr_stat  = w_wr && (PADDR[3:2] == REG_STATUS);
  assign w_clr      = w_wr_ctrl & PWDATA[CTRL_CLR];
  assign w_en_nxt   = w_wr_ctrl ? PWDATA[CTRL_EN] : r_en;
  assign w_cnt_sat  = (r_cnt == CNT_MAX);
  assign w_hcnt_sat = (r_hcnt == CNT_MAX);
  assign w_unused   = ^{PADDR[31:4], PADDR[1:0], PWDATA[31:3]};

  // Statement order sets priority: W1C, then hardware sets, then clr overrides everything.
  always_ff @(posedge PCLK) begin
    if (PRESERN) begin
      r_state   <= IDLE;
      r_en      <= 1'b0;
      r_irq_en  <= 1'b0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_ovf     <= 1'b0;
      r_high    <= '0;
      r_period  <= '0;
      r_cnt     <= '0;
      r_hcnt    <= '0;
      r_idle    <= '0;
    end else begin
      if (w_wr_ctrl) begin
        r_en     <= PWDATA[CTRL_EN];
        r_irq_en <= PWDATA[CTRL_IRQ_EN];
      end
      if (w_wr_stat) begin
        if (PWDATA[ST_VALID])   r_valid   <= 1'b0;
        if (PWDATA[ST_TIMEOUT]) r_timeout <= 1'b0;
        if (PWDATA[ST_OVF])     r_ovf     <= 1'b0;
      end
      if (!r_en) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_hcnt  <= '0;
        r_idle  <= '0;
      end else if (!w_any_edge && r_idle == IDLE_LAST) begin
        r_timeout <= 1'b1;
        r_state   <= WAIT_RISE;
        r_cnt     <= '0;
        r_hcnt    <= '0;
        r_idle    <= '0;
      end else begin
        r_idle <= w_any_edge ? '0 : r_idle + IDLE_W'(1);
        case (r_state)
          IDLE: r_state <= WAIT_RISE;
          WAIT_RISE: begin
            if (w_rise) begin
              r_state <= HIGH;
              r_cnt   <= CNT_W'(1);
              r_hcnt  <= CNT_W'(1);
            end
          end
          HIGH: begin
            if (w_cnt_sat) r_ovf <= 1'b1;
            else           r_cnt <= r_cnt + CNT_W'(1);
            if (w_fall)          r_state <= LOW;
            else if (w_hcnt_sat) r_ovf   <= 1'b1;
            else                 r_hcnt  <= r_hcnt + CNT_W'(1);
          end
          LOW: begin
            if (w_rise) begin
              r_high   <= r_hcnt;
              r_period <= r_cnt;
              r_valid  <= 1'b1;
              r_cnt    <= CNT_W'(1);
              r_hcnt   <= CNT_W'(1);
              r_state  <= HIGH;
            end else if (w_cnt_sat) begin
              r_ovf <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          default: r_state <= IDLE;
        endcase
      end
      if (w_clr) begin
        r_high    <= '0;
        r_period  <= '0;
        r_valid   <= 1'b0;
        r_timeout <= 1'b0;
        r_ovf     <= 1'b0;
        r_cnt     <= '0;
        r_hcnt    <= '0;
        r_idle    <= '0;
        r_state   <= w_en_nxt ? WAIT_RISE : IDLE;
      end
    end
  end

  always_comb begin
    PRDATA = '0;
    case (PADDR[3:2])
      REG_CTRL:   PRDATA = {29'b0, 1'b0, r_irq_en, r_en};
      REG_HIGH:   PRDATA = 32'(r_high);
      REG_PERIOD: PRDATA = 32'(r_period);
      REG_STATUS: PRDATA = {29'b0, r_ovf, r_timeout, r_valid};
      default:    PRDATA = '0;
    endcase
  end

  assign PREADY  = 1'b1;
  assign PSLVERR = 1'b0;
  assign irq     = r_irq_en & (r_valid | r_timeout);

endmodule

// File: tb/tb_pwm_pulse_monitor.sv
// Directed bench for pwm_pulse_monitor; expectations adapt to PWM_MON_FILTER_EN.
module tb_pwm_pulse_monitor;
  import pwm_mon_pkg::*;

`ifdef PWM_MON_FILTER_EN
  localparam int unsigned LAT        = 5;
  localparam logic [31:0] G_STATUS   = 32'h0;
  localparam logic [31:0] G_PERIOD   = 32'd100;
  localparam logic [31:0] F_HIGH     = 32'd30;
  localparam logic [31:0] F_PERIOD   = 32'd100;
`else
  localparam int unsigned LAT        = 3;
  localparam logic [31:0] G_STATUS   = 32'h1;
  localparam logic [31:0] G_PERIOD   = 32'd60;
  localparam logic [31:0] F_HIGH     = 32'd1;
  localparam logic [31:0] F_PERIOD   = 32'd40;
`endif

  localparam int MAIN = 0;
  localparam int TO   = 1;
  localparam int SAT  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  psel;
  logic        penable, pwrite, pwm;
  logic [31:0] paddr, pwdata;
  logic [2:0]  rdy, err, irq;
  logic [31:0] prd_main, prd_to, prd_sat;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pwm_pulse_monitor u_main (
    .PCLK(clk), .PRESERN(rst), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PREADY(rdy[0]), .PSLVERR(err[0]), .PRDATA(prd_main),
    .pwm_in(pwm), .irq(irq[0])
  );

  pwm_pulse_monitor #(.TIMEOUT(100)) u_to (
    .PCLK(clk), .PRESERN(rst), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PREADY(rdy[1]), .PSLVERR(err[1]), .PRDATA(prd_to),
    .pwm_in(pwm), .irq(irq[1])
  );

  pwm_pulse_monitor #(.CNT_W(8)) u_sat (
    .PCLK(clk), .PRESERN(rst), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PREADY(rdy[2]), .PSLVERR(err[2]), .PRDATA(prd_sat),
    .pwm_in(pwm), .irq(irq[2])
  );

  typedef struct {
    int unsigned hi;
    int unsigned lo;
    logic [31:0] exp_high;
    logic [31:0] exp_period;
    logic [31:0] exp_status;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apb_wr(input int idx, input logic [3:0] a, input logic [31:0] d);
    psel    = 3'(1 << idx);
    pwrite  = 1'b1;
    penable = 1'b0;
    paddr   = {28'b0, a};
    pwdata  = d;
    ticks(1);
    penable = 1'b1;
    ticks(1);
    psel    = '0;
    penable = 1'b0;
    pwrite  = 1'b0;
  endtask

  task automatic rd_chk(input int idx, input logic [3:0] a, input logic [31:0] exp, input string nm);
    logic [31:0] d;
    psel   = 3'(1 << idx);
    pwrite = 1'b0;
    paddr  = {28'b0, a};
    #1;
    d = (idx == MAIN) ? prd_main : (idx == TO) ? prd_to : prd_sat;
    psel = '0;
    chk(nm, d, exp);
  endtask

  task automatic pulse(input int unsigned hi, input int unsigned lo);
    pwm = 1'b1;
    ticks(int'(hi));
    pwm = 1'b0;
    ticks(int'(lo));
  endtask

  initial begin
    vecs[0] = '{150, 850, 32'd150, 32'd1000, 32'h1};
    vecs[1] = '{2,   3,   32'd2,   32'd5,    32'h1};
    vecs[2] = '{7,   2,   32'd7,   32'd9,    32'h1};
    vecs[3] = '{40,  10,  32'd40,  32'd50,   32'h1};
    vecs[4] = '{3,   97,  32'd3,   32'd100,  32'h1};

    rst = 1'b1; psel = '0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pwm = 1'b0;
    ticks(3);

    rd_chk(MAIN, 4'h0, 32'h0, "rst_ctrl");
    rd_chk(MAIN, 4'h4, 32'h0, "rst_high");
    rd_chk(MAIN, 4'h8, 32'h0, "rst_period");
    rd_chk(MAIN, 4'hC, 32'h0, "rst_status");
    chk("rst_irq", {31'b0, irq[0]}, 32'h0);
    chk("rst_state", {30'b0, u_main.r_state}, {30'b0, IDLE});
    chk("pready_pslverr", {30'b0, rdy[0], err[0]}, 32'h2);
    rst = 1'b0;
    ticks(2);

    for (int i = 0; i < 5; i++) begin
      pwm = 1'b0;
      ticks(int'(LAT) + 3);
      apb_wr(MAIN, 4'h0, 32'h5);
      pulse(vecs[i].hi, vecs[i].lo);
      pwm = 1'b1;
      ticks(int'(LAT) + 2);
      rd_chk(MAIN, 4'h4, vecs[i].exp_high,   $sformatf("v%0d_high", i));
      rd_chk(MAIN, 4'h8, vecs[i].exp_period, $sformatf("v%0d_period", i));
      rd_chk(MAIN, 4'hC, vecs[i].exp_status, $sformatf("v%0d_status", i));
    end

    // irq and W1C
    apb_wr(MAIN, 4'h0, 32'h3);
    rd_chk(MAIN, 4'h0, 32'h3, "ctrl_rb");
    chk("irq_set", {31'b0, irq[0]}, 32'h1);
    apb_wr(MAIN, 4'hC, 32'h1);
    rd_chk(MAIN, 4'hC, 32'h0, "w1c_status");
    chk("irq_clr", {31'b0, irq[0]}, 32'h0);
    pwm = 1'b0;
    ticks(20);
    pwm = 1'b1;
    ticks(int'(LAT) - 1);
    apb_wr(MAIN, 4'hC, 32'h1);
    rd_chk(MAIN, 4'hC, 32'h1, "w1c_vs_capture");
    chk("irq_recap", {31'b0, irq[0]}, 32'h1);

    // en=0 holds results, clr zeroes them
    pwm = 1'b0;
    ticks(int'(LAT) + 3);
    apb_wr(MAIN, 4'h0, 32'h7);
    pulse(20, 30);
    pwm = 1'b1;
    ticks(int'(LAT) + 2);
    rd_chk(MAIN, 4'h4, 32'd20, "pre_dis_high");
    ticks(5);
    apb_wr(MAIN, 4'h0, 32'h0);
    ticks(1);
    chk("dis_state", {30'b0, u_main.r_state}, {30'b0, IDLE});
    pulse(10, 10);
    pulse(10, 10);
    rd_chk(MAIN, 4'h4, 32'd20, "dis_high");
    rd_chk(MAIN, 4'h8, 32'd50, "dis_period");
    rd_chk(MAIN, 4'hC, 32'h1,  "dis_status");
    ticks(int'(LAT) + 3);
    apb_wr(MAIN, 4'h0, 32'h5);
    rd_chk(MAIN, 4'h4, 32'h0, "clr_high");
    rd_chk(MAIN, 4'h8, 32'h0, "clr_period");
    rd_chk(MAIN, 4'hC, 32'h0, "clr_status");
    chk("clr_state", {30'b0, u_main.r_state}, {30'b0, WAIT_RISE});
    pulse(10, 10);
    pwm = 1'b1;
    ticks(int'(LAT) - 1);
    apb_wr(MAIN, 4'h0, 32'h5);
    rd_chk(MAIN, 4'h4, 32'h0, "clr_vs_cap_high");
    rd_chk(MAIN, 4'hC, 32'h0, "clr_vs_cap_status");

    // timeout at exactly TIMEOUT cycles
    pwm = 1'b0;
    ticks(int'(LAT) + 3);
    apb_wr(TO, 4'h0, 32'h1);
    ticks(99);
    rd_chk(TO, 4'hC, 32'h0, "to_before");
    ticks(1);
    rd_chk(TO, 4'hC, 32'h2, "to_set");
    chk("to_state", {30'b0, u_to.r_state}, {30'b0, WAIT_RISE});

    // saturation with CNT_W=8
    apb_wr(SAT, 4'h0, 32'h5);
    pwm = 1'b1;
    ticks(300);
    rd_chk(SAT, 4'hC, 32'h4, "sat_ovf");
    pwm = 1'b0;
    ticks(20);
    pwm = 1'b1;
    ticks(int'(LAT) + 2);
    rd_chk(SAT, 4'h4, 32'd255, "sat_high");
    rd_chk(SAT, 4'h8, 32'd255, "sat_period");
    rd_chk(SAT, 4'hC, 32'h5,   "sat_status");

    // one-cycle glitch during the low phase
    pwm = 1'b0;
    ticks(int'(LAT) + 3);
    apb_wr(MAIN, 4'h0, 32'h5);
    pulse(30, 70);
    pwm = 1'b1;
    ticks(int'(LAT) + 2);
    rd_chk(MAIN, 4'h8, 32'd100, "g_pre_period");
    apb_wr(MAIN, 4'hC, 32'h1);
    ticks(30 - int'(LAT) - 4);
    pwm = 1'b0;
    ticks(30);
    pwm = 1'b1;
    ticks(1);
    pwm = 1'b0;
    ticks(39);
    rd_chk(MAIN, 4'hC, G_STATUS, "g_status");
    rd_chk(MAIN, 4'h8, G_PERIOD, "g_period");
    pwm = 1'b1;
    ticks(int'(LAT) + 2);
    rd_chk(MAIN, 4'h4, F_HIGH,   "g_final_high");
    rd_chk(MAIN, 4'h8, F_PERIOD, "g_final_period");

    // reset mid-measurement
    apb_wr(MAIN, 4'h0, 32'h3);
    chk("pre_rst_irq", {31'b0, irq[0]}, 32'h1);
    rst = 1'b1;
    ticks(1);
    rd_chk(MAIN, 4'h0, 32'h0, "mid_rst_ctrl");
    rd_chk(MAIN, 4'h4, 32'h0, "mid_rst_high");
    rd_chk(MAIN, 4'h8, 32'h0, "mid_rst_period");
    rd_chk(MAIN, 4'hC, 32'h0, "mid_rst_status");
    chk("mid_rst_irq", {31'b0, irq[0]}, 32'h0);
    chk("mid_rst_state", {30'b0, u_main.r_state}, {30'b0, IDLE});
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
